// File: rtl/caesar_stream_cipher_if.sv
// caesar_stream_cipher_if: character stream handshake bundle (input beat, mode, output beat)
interface caesar_stream_cipher_if #(parameter int LANES = 4);
  logic in_valid, in_ready, mode, out_valid, out_ready;
  logic [8*LANES-1:0] in_data, out_data;
  modport master(output in_valid, in_data, mode, out_ready, input in_ready, out_valid, out_data);
  modport slave(input in_valid, in_data, mode, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/caesar_stream_cipher.sv
// caesar_stream_cipher: multi-lane Caesar encrypt/decrypt stream with one-cycle latency
module caesar_stream_cipher #(
  parameter int LANES = 4,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [4:0] key_in,
  input  logic key_load,
  output logic key_err,
  output logic [CNT_W-1:0] beat_count,
  caesar_stream_cipher_if.slave s
);
  typedef enum logic {UNKEYED, RUN} state_t;
  state_t state_q, state_d;
  logic [4:0] key_q, key_d;
  logic key_ok, accept, out_valid_q;
  logic [8*LANES-1:0] out_q, xf;
  function automatic logic [7:0] shift_char(input logic [7:0] c, input logic [4:0] k, input logic dec);
    logic up, lo;
    logic [7:0] base, off;
    logic [5:0] sum;
    up = c >= 8'h41 && c <= 8'h5A;
    lo = c >= 8'h61 && c <= 8'h7A;
    base = up ? 8'h41 : 8'h61;
    off = c - base;
    sum = off[5:0] + (dec ? 6'd26 - {1'b0, k} : {1'b0, k});
    sum = sum >= 6'd26 ? sum - 6'd26 : sum;
    return (up || lo) ? base + {2'b00, sum} : c;
  endfunction
  assign key_ok = key_load && key_in <= 5'd25;
  assign s.in_ready = state_q == RUN && (!out_valid_q || s.out_ready);
  assign accept = s.in_valid && s.in_ready;
  assign s.out_valid = out_valid_q;
  assign s.out_data = out_q;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign xf[8*i +: 8] = shift_char(s.in_data[8*i +: 8], key_q, s.mode);
  end
  // next state and key: any legal load arms the stream and replaces the key
  always_comb begin
    state_d = key_ok ? RUN : state_q;
    key_d = key_ok ? key_in : key_q;
  end
  // state, key, output beat register and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNKEYED;
      key_q <= '0;
      key_err <= 1'b0;
      out_valid_q <= 1'b0;
      out_q <= '0;
      beat_count <= '0;
    end else begin
      state_q <= state_d;
      key_q <= key_d;
      key_err <= key_load && !key_ok;
      out_valid_q <= accept || (out_valid_q && !s.out_ready);
      out_q <= accept ? xf : out_q;
      beat_count <= beat_count + CNT_W'(accept);
    end
  end
endmodule

// File: doc/caesar_stream_cipher.md
CAESAR_STREAM_CIPHER -- requirements
Module: caesar_stream_cipher

Interface
REQ-001 The block SHALL have parameter LANES, default 4, giving the number of 8-bit characters per beat (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of the beat counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port key_in, input, 5 bits: shift amount, legal range 0..25.
REQ-006 The block SHALL have port key_load, input, 1 bit: single-cycle strobe loading key_in.
REQ-007 The block SHALL have port key_err, output, 1 bit: one-cycle pulse when a key load is rejected.
REQ-008 The block SHALL have port mode, input, 1 bit: 0 = encrypt, 1 = decrypt; sampled with each accepted beat.
REQ-009 The block SHALL have port in_valid, input, 1 bit: an input beat is present.
REQ-010 The block SHALL have port in_ready, output, 1 bit: the block can accept the input beat.
REQ-011 The block SHALL have port in_data, input, 8*LANES bits: characters, lane 0 in bits [7:0].
REQ-012 The block SHALL have port out_valid, output, 1 bit: an output beat is present.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the sink accepts the output beat.
REQ-014 The block SHALL have port out_data, output, 8*LANES bits: transformed characters, same lane order.
REQ-015 The block SHALL have port beat_count, output, CNT_W bits: number of beats accepted since reset.

Function
REQ-016 The FSM SHALL have two states, UNKEYED and RUN; UNKEYED -> RUN on the first accepted key load, with no other transitions except reset.
REQ-017 A key load SHALL be accepted when key_load=1 and key_in<=25; a key load with key_in>=26 SHALL leave the key and the state unchanged and SHALL pulse key_err for one cycle.
REQ-018 A key load SHALL be accepted in either state, and the new key SHALL apply only to beats accepted in later cycles; a beat accepted in the same cycle SHALL use the old key.
REQ-019 in_ready SHALL equal (state==RUN) AND (out_valid==0 OR out_ready==1).
REQ-020 A beat SHALL be accepted when in_valid and in_ready are both 1.
REQ-021 Latency SHALL be one cycle: out_data and out_valid=1 are registered on the edge that accepts the beat.
REQ-022 A full throughput of one beat per cycle SHALL be sustained while out_ready=1.
REQ-023 Per lane, an uppercase letter c (0x41..0x5A) SHALL be encrypted to 0x41+((c-0x41+k) mod 26) and decrypted to 0x41+((c-0x41+26-k) mod 26).
REQ-024 Lowercase letters (0x61..0x7A) SHALL be transformed with the same rule as REQ-023 using base 0x61.
REQ-025 All other byte values SHALL pass through unchanged.
REQ-026 The transformation SHALL preserve case, and k=0 SHALL give the identity transform.
REQ-027 All lanes SHALL be computed in parallel with combinational modular arithmetic; no divider and no multi-cycle operation SHALL be used.
REQ-028 While out_valid=1 and out_ready=0, out_data SHALL hold stable and in_ready SHALL be 0.
REQ-029 out_valid SHALL clear on the cycle after a handshake unless a new beat is accepted in the same cycle.
REQ-030 beat_count SHALL increment by 1 per accepted beat and SHALL wrap from 2^CNT_W-1 to 0.

Reset
REQ-031 While rst_n=0, the block SHALL immediately set state=UNKEYED, key=0, out_valid=0, out_data=0, key_err=0, beat_count=0 and in_ready=0, regardless of the clock.
REQ-032 A reset asserted mid-stream SHALL discard any pending output beat, and a key load SHALL be required after reset before any beat is accepted.

Verification
REQ-033 The bench SHALL check: after reset with no key load and in_valid=1 held for 5 cycles -> in_ready=0 and out_valid=0 throughout.
REQ-034 The bench SHALL check: key_in=3 loaded, mode=0, in_data=0x215A7978 ("xyZ!") -> one cycle later out_valid=1 and out_data=0x21436261 ("abC!").
REQ-035 The bench SHALL check: key=3, mode=1, in_data=0x21436261 -> out_data=0x215A7978; with key=0, any input is returned unchanged.
REQ-036 The bench SHALL check: 3 back-to-back beats with out_ready held at 0 for 2 cycles -> the first output holds stable, in_ready=0, and once out_ready=1 all 3 outputs appear in order with beat_count=3.
REQ-037 The bench SHALL check: key_in=26 with key_load=1 -> key_err=1 for one cycle and subsequent outputs still use the previous key of 3.
REQ-038 The bench SHALL check: rst_n pulsed low while out_valid=1 -> out_valid=0, beat_count=0 and in_ready=0 until the next accepted key load.
